// File: rtl/ac_motor_pwm_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_decoder_pkg
// Shared definitions for the AC motor PWM decoder:
//   - decoder FSM state encoding
//   - per-period counter operation encoding
//   - default counter width and carrier-loss timeout
// ---------------------------------------------------------------------------
package ac_motor_pwm_decoder_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int MAX_PERIOD_DEF = 65535;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } state_e;

  // Counter operation applied on a clock edge:
  //   OP_CLR  - force to zero
  //   OP_LOAD - start a new period with this cycle's contribution
  //   OP_INC  - accumulate this cycle's contribution
  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/ac_motor_pwm_decoder_if.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_decoder_if
// Bundle between the bridge-drive/carrier side and the decoder.
//   master : drives enable, cw, ccw, out1, en1, out2, en2;
//            receives duty, period, float_cnt, valid, timeout, dir_err
//   slave  : the decoder (mirror image of master)
// ---------------------------------------------------------------------------
interface ac_motor_pwm_decoder_if #(
  parameter int CNT_W = 16
);

  logic                  enable;
  logic                  cw;
  logic                  ccw;
  logic                  out1;
  logic                  en1;
  logic                  out2;
  logic                  en2;
  logic signed [CNT_W:0] duty;
  logic [CNT_W-1:0]      period;
  logic [CNT_W-1:0]      float_cnt;
  logic                  valid;
  logic                  timeout;
  logic                  dir_err;

  modport master (
    output enable, cw, ccw, out1, en1, out2, en2,
    input  duty, period, float_cnt, valid, timeout, dir_err
  );

  modport slave (
    input  enable, cw, ccw, out1, en1, out2, en2,
    output duty, period, float_cnt, valid, timeout, dir_err
  );

endinterface

// File: rtl/ac_motor_pwm_leg_counter.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_leg_counter
// Per-leg high-cycle and float-cycle counter for one carrier period.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   op             - clear / load-on-sync / accumulate
//   hi             - this cycle counts as "leg driven high"
//   fl             - this cycle counts as "floating" for this counter
//   high_cnt       - accumulated high cycles (current period so far)
//   flt_cnt        - accumulated float cycles (current period so far)
// ---------------------------------------------------------------------------
module ac_motor_pwm_leg_counter
  import ac_motor_pwm_decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  cnt_op_e          op,
  input  logic             hi,
  input  logic             fl,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] flt_cnt
);

  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] flt_q,  flt_d;

  always_comb begin
    high_d = high_q;
    flt_d  = flt_q;
    unique case (op)
      OP_CLR: begin
        high_d = '0;
        flt_d  = '0;
      end
      OP_LOAD: begin
        high_d = CNT_W'(hi);
        flt_d  = CNT_W'(fl);
      end
      OP_INC: begin
        high_d = high_q + CNT_W'(hi);
        flt_d  = flt_q  + CNT_W'(fl);
      end
      default: begin
        high_d = '0;
        flt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
      flt_q  <= '0;
    end else begin
      high_q <= high_d;
      flt_q  <= flt_d;
    end
  end

  assign high_cnt = high_q;
  assign flt_cnt  = flt_q;

endmodule

// File: rtl/ac_motor_pwm_decoder.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_decoder
// Reconstructs the applied signed duty of an H-bridge PWM once per carrier
// period. A period starts on each rising edge of cw (triangle at minimum).
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus.slave  - inputs : enable, cw, ccw, out1, en1, out2, en2
//                outputs: duty (signed high_A - high_B), period, float_cnt,
//                         valid (1-cycle strobe), timeout (sticky until
//                         next sync), dir_err (sticky until reset)
// ---------------------------------------------------------------------------
module ac_motor_pwm_decoder
  import ac_motor_pwm_decoder_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_PERIOD = MAX_PERIOD_DEF
) (
  input logic                   clk,
  input logic                   reset,
  ac_motor_pwm_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CYC = CNT_W'(MAX_PERIOD);

  state_e                state_q, state_d;
  cnt_op_e               op;
  logic                  cw_q, cw_d;
  logic                  sync;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic signed [CNT_W:0] duty_q, duty_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      float_q, float_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;
  logic                  dir_err_q, dir_err_d;

  logic                  h_a, h_b, fl_a, fl_b;
  logic [CNT_W-1:0]      high_a, high_b, flt_a, flt_b;

  function automatic logic signed [CNT_W:0] leg_diff(input logic [CNT_W-1:0] a,
                                                     input logic [CNT_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  assign cw_d = bus.cw;
  assign sync = bus.cw & ~cw_q;

  assign h_a  = bus.en1 & bus.out1;
  assign h_b  = bus.en2 & bus.out2;
  // Float cycles are split so the two legs never count the same cycle:
  // leg B only counts when leg A is enabled, so fl_a + fl_b == ~en1 | ~en2.
  assign fl_a = ~bus.en1;
  assign fl_b = ~bus.en2 & bus.en1;

  ac_motor_pwm_leg_counter #(.CNT_W(CNT_W)) u_leg_a (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .hi       (h_a),
    .fl       (fl_a),
    .high_cnt (high_a),
    .flt_cnt  (flt_a)
  );

  ac_motor_pwm_leg_counter #(.CNT_W(CNT_W)) u_leg_b (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .hi       (h_b),
    .fl       (fl_b),
    .high_cnt (high_b),
    .flt_cnt  (flt_b)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (sync) state_d = ST_MEASURE;
        ST_MEASURE: if (!sync && (cyc_q >= MAX_CYC)) state_d = ST_LOST;
        ST_LOST:    if (sync) state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    op        = OP_CLR;
    valid_d   = 1'b0;
    duty_d    = duty_q;
    period_d  = period_q;
    float_d   = float_q;
    timeout_d = timeout_q;
    dir_err_d = dir_err_q | (bus.cw & bus.ccw);
    if (bus.enable) begin
      unique case (state_q)
        ST_IDLE: begin
          // The period in flight when we arrive is partial; start fresh.
          if (sync) begin
            op        = OP_LOAD;
            timeout_d = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (sync) begin
            // Report the period that just ended; the sync cycle opens the next.
            op       = OP_LOAD;
            valid_d  = 1'b1;
            duty_d   = leg_diff(high_a, high_b);
            period_d = cyc_q;
            float_d  = flt_a + flt_b;
          end else if (cyc_q >= MAX_CYC) begin
            op        = OP_CLR;
            timeout_d = 1'b1;
          end else begin
            op = OP_INC;
          end
        end
        ST_LOST: begin
          if (sync) begin
            op        = OP_LOAD;
            timeout_d = 1'b0;
          end
        end
        default: op = OP_CLR;
      endcase
    end
  end

  always_comb begin
    unique case (op)
      OP_LOAD: cyc_d = CNT_W'(1);
      OP_INC:  cyc_d = cyc_q + CNT_W'(1);
      default: cyc_d = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cw_q      <= 1'b0;
      cyc_q     <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      float_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      dir_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      cyc_q     <= cyc_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      float_q   <= float_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      dir_err_q <= dir_err_d;
    end
  end

  assign bus.duty      = duty_q;
  assign bus.period    = period_q;
  assign bus.float_cnt = float_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.dir_err   = dir_err_q;

endmodule

// File: tb/tb_ac_motor_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_ac_motor_pwm_decoder
// Directed bench: carrier periods described as {length, leg A high cycles,
// leg B high cycles, leg A float cycles} plus the measurement expected to be
// reported while that period runs (i.e. the previous period's figures).
// ---------------------------------------------------------------------------
module tb_ac_motor_pwm_decoder;

  localparam int CNT_W = 16;
  localparam int MAXP  = 200;

  typedef struct {
    int len;
    int a;
    int b;
    int f;
    int ev;
    int duty;
    int per;
    int flt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ac_motor_pwm_decoder_if #(.CNT_W(CNT_W)) bus ();

  ac_motor_pwm_decoder #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int                    vtot = 0;
  logic signed [CNT_W:0] cap_duty = '0;
  logic [CNT_W-1:0]      cap_per  = '0;
  logic [CNT_W-1:0]      cap_flt  = '0;
  logic                  en_val   = 1'b1;
  int                    dir_idx  = -1;
  logic                  to_at1   = 1'b0;

  // Capture every valid strobe away from the active edge.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vtot     = vtot + 1;
      cap_duty = bus.duty;
      cap_per  = bus.period;
      cap_flt  = bus.float_cnt;
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive ncyc cycles of a carrier period of length len. cw is high for the
  // first half (so cycle 0 is a sync), ccw is its complement.
  task automatic run_period(input int len, input int a, input int b,
                            input int f, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 1) to_at1 = bus.timeout;
      bus.enable = en_val;
      bus.cw     = (i < len / 2);
      bus.ccw    = (i >= len / 2) || (i == dir_idx);
      bus.en1    = !(i >= len - f);
      bus.out1   = (i < a) || (i >= len - f);
      bus.en2    = 1'b1;
      bus.out2   = (i < b);
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int base;
    base = vtot;
    run_period(v.len, v.a, v.b, v.f, v.len);
    chk({tag, "_nvalid"}, vtot - base, v.ev);
    if (v.ev == 1) begin
      chk({tag, "_duty"},   cap_duty, v.duty);
      chk({tag, "_sign"},   cap_duty[CNT_W], (v.duty < 0));
      chk({tag, "_period"}, cap_per,  v.per);
      chk({tag, "_float"},  cap_flt,  v.flt);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   bus.valid,     0);
    chk({tag, "_duty"},    bus.duty,      0);
    chk({tag, "_period"},  bus.period,    0);
    chk({tag, "_float"},   bus.float_cnt, 0);
    chk({tag, "_timeout"}, bus.timeout,   0);
    chk({tag, "_dir_err"}, bus.dir_err,   0);
  endtask

  vec_t tbl [7];

  initial begin
    int base;
    logic [CNT_W:0] raw;

    tbl[0] = '{len:100, a:60, b:40,  f:0,  ev:0, duty:0,    per:0,   flt:0};
    tbl[1] = '{len:100, a:10, b:90,  f:0,  ev:1, duty:20,   per:100, flt:0};
    tbl[2] = '{len:100, a:60, b:40,  f:25, ev:1, duty:-80,  per:100, flt:0};
    tbl[3] = '{len:80,  a:30, b:30,  f:0,  ev:1, duty:20,   per:100, flt:25};
    tbl[4] = '{len:150, a:0,  b:150, f:0,  ev:1, duty:0,    per:80,  flt:0};
    tbl[5] = '{len:50,  a:50, b:0,   f:0,  ev:1, duty:-150, per:150, flt:0};
    tbl[6] = '{len:100, a:60, b:40,  f:0,  ev:1, duty:50,   per:50,  flt:0};

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.cw     = 1'b0;
    bus.ccw    = 1'b0;
    bus.out1   = 1'b0;
    bus.en1    = 1'b1;
    bus.out2   = 1'b0;
    bus.en2    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_row(tbl[k], $sformatf("row%0d", k));
      if (k == 2) begin
        raw = cap_duty;
        chk("row2_duty_bits", raw, 17'h1FFB0);
      end
    end

    // Carrier loss: last sync is cycle 0 of this period, then cw stays low.
    run_period(100, 60, 40, 0, 100);
    base = vtot;
    for (int m = 100; m <= 205; m++) begin
      @(negedge clk);
      if (m == 200) chk("timeout_before", bus.timeout, 0);
      if (m == 201) chk("timeout_at_max", bus.timeout, 1);
      bus.cw  = 1'b0;
      bus.ccw = 1'b1;
    end
    chk("timeout_no_valid", vtot - base, 0);
    chk("timeout_sticky", bus.timeout, 1);

    // Carrier returns: timeout clears on the sync, first period discarded.
    base = vtot;
    run_period(100, 10, 90, 0, 100);
    chk("timeout_cleared", to_at1, 0);
    chk("recover_nvalid", vtot - base, 0);
    run_row('{len:100, a:60, b:40, f:0, ev:1, duty:-80, per:100, flt:0}, "recover");

    // Illegal direction flags for a single cycle.
    chk("dir_err_before", bus.dir_err, 0);
    dir_idx = 10;
    run_row('{len:100, a:10, b:90, f:0, ev:1, duty:20, per:100, flt:0}, "dirrow");
    dir_idx = -1;
    chk("dir_err_set", bus.dir_err, 1);
    run_row('{len:100, a:60, b:40, f:0, ev:1, duty:-80, per:100, flt:0}, "dirhold");
    chk("dir_err_held", bus.dir_err, 1);

    // Reset in the middle of a period.
    run_period(100, 60, 40, 0, 30);
    @(negedge clk);
    reset   = 1'b1;
    bus.cw  = 1'b0;
    bus.ccw = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    run_row('{len:100, a:10, b:90, f:0, ev:0, duty:0,   per:0,   flt:0}, "postrst0");
    run_row('{len:100, a:60, b:40, f:0, ev:1, duty:-80, per:100, flt:0}, "postrst1");

    // Enable dropped mid-period: nothing emitted, results hold.
    run_period(100, 10, 90, 0, 60);
    en_val = 1'b0;
    base   = vtot;
    run_period(100, 10, 90, 0, 100);
    chk("disable_nvalid", vtot - base, 0);
    chk("disable_duty_hold", bus.duty, 20);
    chk("disable_period_hold", bus.period, 100);
    en_val = 1'b1;
    run_row('{len:100, a:60, b:40, f:0, ev:0, duty:0,   per:0,   flt:0}, "reen0");
    run_row('{len:100, a:10, b:90, f:0, ev:1, duty:20,  per:100, flt:0}, "reen1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac_motor_pwm_decoder.md
Name: ac_motor_pwm_decoder

Overview:
- Receiving end of the AC motor PWM path: samples the bridge drive signals (out1/out2/en1/en2) produced by the comparator and reconstructs the applied signed duty once per carrier period.
- Carrier period boundaries come from the triangle generator's direction flags (cw/ccw).
- Used as an in-system loopback monitor and as a self-check in benches.
- Also flags floating legs, carrier loss (timeout) and illegal direction flags.

Parameters:
- CNT_W, 16, width of per-period cycle counters.
- MAX_PERIOD, 65535, carrier-loss timeout in clk cycles; must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  decoder enable; 0 forces IDLE.
- cw  in  1  triangle rising-direction flag.
- ccw  in  1  triangle falling-direction flag.
- out1  in  1  leg A level.
- en1  in  1  leg A enable.
- out2  in  1  leg B level.
- en2  in  1  leg B enable.
- duty  out  CNT_W+1  signed, high_A minus high_B cycles of last period.
- period  out  CNT_W  cycle count of last completed period.
- float_cnt  out  CNT_W  cycles in last period with en1=0 or en2=0.
- valid  out  1  one-cycle strobe; new duty/period/float_cnt.
- timeout  out  1  sticky carrier-loss flag, cleared on next sync.
- dir_err  out  1  sticky; set when cw&ccw=1 in any cycle, cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, cw_d=0, all counters 0, state IDLE.
- sync = cw & ~cw_d (cw rising edge, triangle at minimum). cw_d is registered every cycle, including in IDLE.
- Per-cycle contributions:
  - hA = en1&out1
  - hB = en2&out2
  - fl = ~en1 | ~en2
- States:
  - IDLE: wait for sync with enable=1, then go to MEASURE. The first partial period is always discarded.
  - MEASURE: count every cycle.
    - On sync: latch results, pulse valid, restart counters.
    - If the cycle counter reaches MAX_PERIOD without a sync: set timeout, go to LOST. No valid pulse.
  - LOST: counters held at 0. On sync, clear timeout and go to MEASURE (a fresh period starts there; nothing is emitted).
- Sync cycle belongs to the new period. Counters load with that cycle's contribution:
  - cyc=1
  - cntA=hA
  - cntB=hB
  - cntF=fl
- On sync in MEASURE, outputs register the old counter values:
  - period = cyc
  - duty = cntA - cntB, sign-extended to CNT_W+1
  - float_cnt = cntF
- Latency: valid asserts in the cycle after the sync cycle, i.e. 2 clk after cw rises at the input.
- High counters cannot exceed cyc, so no saturation is needed. cyc is bounded by MAX_PERIOD.
- enable=0 in any state: next state is IDLE, counters cleared. duty/period/float_cnt hold their last values, valid=0, timeout holds.
- Reset mid-period: no valid pulse is emitted; the partial period is lost.
- dir_err is independent of state and enable.

Decomposition:
- Shared ac_motor package holds:
  - state encoding (IDLE, MEASURE, LOST)
  - CNT_W default
  - MAX_PERIOD default
- One natural sub-module, ac_motor_pwm_leg_counter: a per-leg high/float counter with load-on-sync, instantiated twice. The float count is summed in the top.

Test Plan:
- Sync every 100 cycles; leg A high 60 cycles, leg B high 40, both enabled -> after second sync valid=1, duty=+20, period=100, float_cnt=0.
- Leg A high 10, leg B high 90 per 100-cycle period -> duty=-80. Sign extension checked at CNT_W+1 bits.
- en1=0 for 25 cycles of a 100-cycle period -> float_cnt=25; duty excludes those cycles.
- Stop cw after one period, MAX_PERIOD=200 -> timeout=1 exactly 200 cycles after the last sync with no valid. Restart cw -> timeout clears on sync, valid only after the following full period.
- Force cw=ccw=1 for one cycle -> dir_err=1 and held until reset. Reset asserted mid-period -> all outputs 0, no valid; first valid only after two syncs post-reset.
- Lower enable mid-period -> valid never fires, duty holds its old value. Re-enable -> first valid only after one full discarded period.
